ff_pipe: RTL and testbench
==========================

// Module: ff_pipe
// PURPOSE
//  Parametrised elastic register pipeline: DEPTH stages of WIDTH-bit enabled flip-flops with
//  per-stage valid bits and a valid/ready handshake. Bubbles collapse; throughput is 1 word/cycle.
//  Next generation of the 1-bit enabled DFF. Used as a retiming/buffer stage between datapath blocks.
// PARAMETERS
//  WIDTH  8  data width in bits (>=1)
//  DEPTH  3  number of register stages (>=1)
// PORTS
//  CLK        in   1      clock; all state updates on the rising edge
//  RESET      in   1      synchronous reset, active-high
//  EN         in   1      global enable; 0 = freeze all state, no transfers
//  FLUSH      in   1      synchronous clear of all valid bits
//  IN_VALID   in   1      upstream word present
//  IN_READY   out  1      pipeline accepts IN_DATA this cycle
//  IN_DATA    in   WIDTH  upstream word
//  OUT_VALID  out  1      OUT_DATA holds a valid word
//  OUT_READY  in   1      downstream accepts the word
//  OUT_DATA   out  WIDTH  data of the last stage
//  OCC        out  $clog2(DEPTH+1)  count of valid stages (only with FF_PIPE_OCC_EN)
// BEHAVIOUR
//  - Reset and clock are fixed: one clock CLK; RESET is synchronous, active-high.
//  - State: v[i] and d[i] for i=0..DEPTH-1; stage 0 is the input, stage DEPTH-1 drives OUT_*.
//  - Ready chain (combinational): rdy[DEPTH-1] = ~v[DEPTH-1] | OUT_READY;
//    rdy[i] = ~v[i] | rdy[i+1]. IN_READY = EN & ~FLUSH & rdy[0]. OUT_VALID = EN & v[DEPTH-1].
//  - Stage i loads when rdy[i] & EN & ~FLUSH: v[i] <= upstream valid, and d[i] <= upstream data only
//    if upstream valid = 1 (d holds otherwise). Upstream of stage 0 is IN_VALID/IN_DATA.
//  - A stage that is valid and not ready holds both v and d.
//  - Latency: an accepted word appears on OUT_* exactly DEPTH cycles later when stages ahead are empty.
//  - Full pipeline with OUT_READY=1: accepts and emits in the same cycle (no lost slot).
//  - Full pipeline with OUT_READY=0: IN_READY=0 and all stages hold.
//  - EN=0: IN_READY=0, OUT_VALID=0, every register holds. No word is dropped or duplicated.
//  - FLUSH=1 (EN ignored): all v <= 0 next cycle; IN_READY=0 in that cycle; d unchanged.
//  - Priority: RESET > FLUSH > EN.
//  - RESET: all v <= 0 and all d <= 0. Next cycle: OUT_VALID=0, OUT_DATA=0, and IN_READY=1 if EN=1.
//    Reset mid-stream discards all in-flight words.
//  - Handshake: OUT_DATA is stable while OUT_VALID=1 and OUT_READY=0. IN_VALID may be asserted
//    regardless of IN_READY; a transfer occurs only on IN_VALID & IN_READY.
// CONFIGURATION
//  FF_PIPE_OCC_EN defined: OCC port exists = popcount(v), driven from registers, 0 after reset/flush.
//  Not defined: OCC port and its logic are absent; all other behaviour is identical.
// STRUCTURE
//  Package ff_pipe_pkg: FF_PIPE_W_DEF=8, FF_PIPE_D_DEF=3, and the function ff_occ_w(depth)
//  returning $clog2(depth+1).
//  Sub-module ff_pipe_stage (one WIDTH-bit enabled register with valid bit and a local
//  ready term), instantiated DEPTH times in a generate loop.
// TESTING (WIDTH=8, DEPTH=3)
//  1 Reset: RESET=1 for 2 cycles with IN_VALID=1 -> OUT_VALID=0, OUT_DATA=8'h00;
//    after release IN_READY=1 and OCC=0.
//  2 Streaming: OUT_READY=1, send 8'h11,22,33,44 back-to-back -> same words on OUT_DATA,
//    first at cycle +3, one per cycle.
//  3 Backpressure: OUT_READY=0, send 8'hA1..A4 -> IN_READY drops after 3 accepts and OCC=3;
//    OUT_DATA holds A1; on release the output order is A1,A2,A3,A4.
//  4 Full pass-through: full pipeline, OUT_READY=1 and IN_VALID=1 (8'h55) in the same cycle ->
//    IN_READY=1, head emitted, 8'h55 accepted, OCC stays 3.
//  5 EN freeze: EN=0 for 4 cycles mid-stream -> OUT_VALID=0, IN_READY=0, contents preserved;
//    stream resumes with no loss or duplicate.
//  6 Flush/reset mid-op: FLUSH with 2 words in flight -> OCC=0 and OUT_VALID=0 next cycle.
//    RESET and FLUSH together -> d=0.

Source files
------------

// File: rtl/ff_pipe_pkg.sv
// Shared defaults and helpers for the ff_pipe elastic register pipeline.
package ff_pipe_pkg;

  localparam int FF_PIPE_W_DEF = 8;
  localparam int FF_PIPE_D_DEF = 3;

  // Width needed to count 0..depth valid stages.
  function automatic int ff_occ_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ff_pipe_stage.sv
// One elastic pipeline stage: WIDTH-bit data register, valid bit and local ready term.
module ff_pipe_stage
  import ff_pipe_pkg::*;
#(
  parameter int WIDTH = FF_PIPE_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             dn_ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             ready
);

  // An empty stage can always take a word; a full one only if its word leaves.
  assign ready = ~valid | dn_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (en && ready) begin
      valid <= up_valid;
      // Bubbles move forward without disturbing the held data.
      if (up_valid) data <= up_data;
    end
  end

endmodule

// File: rtl/ff_pipe.sv
// Elastic DEPTH-stage register pipeline with valid/ready handshake and collapsing bubbles.
// Optional OCC (valid-stage count) output is built when FF_PIPE_OCC_EN is defined.
module ff_pipe
  import ff_pipe_pkg::*;
#(
  parameter int WIDTH = FF_PIPE_W_DEF,
  parameter int DEPTH = FF_PIPE_D_DEF
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       EN,
  input  logic                       FLUSH,
  input  logic                       IN_VALID,
  output logic                       IN_READY,
  input  logic [WIDTH-1:0]           IN_DATA,
  output logic                       OUT_VALID,
  input  logic                       OUT_READY,
  output logic [WIDTH-1:0]           OUT_DATA
`ifdef FF_PIPE_OCC_EN
  ,
  output logic [ff_occ_w(DEPTH)-1:0] OCC
`endif
);

  logic [DEPTH-1:0] v;
  logic [DEPTH:0]   rdy;
  logic [DEPTH-1:0] up_v;
  logic [WIDTH-1:0] d    [DEPTH];
  logic [WIDTH-1:0] up_d [DEPTH];

  assign rdy[DEPTH] = OUT_READY;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_head
      assign up_v[i] = IN_VALID;
      assign up_d[i] = IN_DATA;
    end else begin : g_body
      assign up_v[i] = v[i-1];
      assign up_d[i] = d[i-1];
    end

    ff_pipe_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk     (CLK),
      .rst     (RESET),
      .en      (EN),
      .flush   (FLUSH),
      .up_valid(up_v[i]),
      .up_data (up_d[i]),
      .dn_ready(rdy[i+1]),
      .valid   (v[i]),
      .data    (d[i]),
      .ready   (rdy[i])
    );
  end

  assign IN_READY  = EN & ~FLUSH & rdy[0];
  assign OUT_VALID = EN & v[DEPTH-1];
  assign OUT_DATA  = d[DEPTH-1];

`ifdef FF_PIPE_OCC_EN
  localparam int OCC_W = ff_occ_w(DEPTH);

  always_comb begin
    OCC = '0;
    for (int i = 0; i < DEPTH; i++) OCC = OCC + OCC_W'(v[i]);
  end
`endif

endmodule

// File: tb/tb_ff_pipe.sv
// Self-checking bench for ff_pipe (WIDTH=8, DEPTH=3): directed scenarios plus randomized traffic.
module tb_ff_pipe;

  localparam int W = 8;
  localparam int D = 3;

  logic         clk = 1'b0;
  logic         rst, en, flush, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] in_data, out_data;
`ifdef FF_PIPE_OCC_EN
  logic [$clog2(D+1)-1:0] occ;
`endif

  always #5 clk = ~clk;

  ff_pipe #(
    .WIDTH(W),
    .DEPTH(D)
  ) dut (
    .CLK      (clk),
    .RESET    (rst),
    .EN       (en),
    .FLUSH    (flush),
    .IN_VALID (in_valid),
    .IN_READY (in_ready),
    .IN_DATA  (in_data),
    .OUT_VALID(out_valid),
    .OUT_READY(out_ready),
    .OUT_DATA (out_data)
`ifdef FF_PIPE_OCC_EN
    ,
    .OCC      (occ)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model: slot array, slot D-1 is the output end.
  logic         mv [D];
  logic [W-1:0] md [D];

  logic         s_in_ready, s_out_valid;
  logic [W-1:0] s_out_data;
  logic [W-1:0] out_q [$];
  int           out_t [$];
  logic [W-1:0] acc_q [$];

  logic [W-1:0] s2_vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [W-1:0] pt_vals [4] = '{8'h51, 8'h52, 8'h53, 8'h55};
  logic [W-1:0] en_vals [6] = '{8'h60, 8'h61, 8'h62, 8'h67, 8'h68, 8'h69};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int model_cnt();
    int n = 0;
    for (int i = 0; i < D; i++) if (mv[i]) n++;
    return n;
  endfunction

  // Any empty slot (or a departing head) lets everything upstream of it move up by one;
  // the new input enters at slot 0.
  task automatic model_step();
    int j;
    if (rst) begin
      for (int i = 0; i < D; i++) begin
        mv[i] = 1'b0;
        md[i] = '0;
      end
    end else if (flush) begin
      for (int i = 0; i < D; i++) mv[i] = 1'b0;
    end else if (en) begin
      j = -1;
      if (out_ready) j = D - 1;
      else for (int i = 0; i < D; i++) if (!mv[i]) j = i;
      for (int i = j; i >= 1; i--) begin
        if (mv[i-1]) md[i] = md[i-1];
        mv[i] = mv[i-1];
      end
      if (j >= 0) begin
        mv[0] = in_valid;
        if (in_valid) md[0] = in_data;
      end
    end
  endtask

  // One clock: sample and compare at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    logic e_rdy, e_ov;
    @(negedge clk);
    s_in_ready  = in_ready;
    s_out_valid = out_valid;
    s_out_data  = out_data;
    e_rdy = en & ~flush & (out_ready | (model_cnt() < D));
    e_ov  = en & mv[D-1];
    check("in_ready", 32'(s_in_ready), 32'(e_rdy));
    check("out_valid", 32'(s_out_valid), 32'(e_ov));
    if (e_ov) check("out_data", 32'(s_out_data), 32'(md[D-1]));
`ifdef FF_PIPE_OCC_EN
    check("occ", 32'(occ), 32'(model_cnt()));
`endif
    if (s_out_valid && out_ready) begin
      out_q.push_back(s_out_data);
      out_t.push_back(cyc);
    end
    if (s_in_ready && in_valid) acc_q.push_back(in_data);
    @(posedge clk);
    model_step();
    cyc++;
    #1;
  endtask

  initial begin
    int t0;
    int n_acc;

    rst = 1'b1; en = 1'b1; flush = 1'b0;
    in_valid = 1'b1; in_data = 8'hEE; out_ready = 1'b0;
    for (int i = 0; i < D; i++) begin
      mv[i] = 1'b0;
      md[i] = '0;
    end
    @(posedge clk);
    #1;

    // Reset held with IN_VALID asserted
    cycle();
    check("rst_out_valid", 32'(s_out_valid), 0);
    check("rst_out_data", 32'(s_out_data), 0);
    cycle();
    check("rst_out_data2", 32'(s_out_data), 0);
    rst = 1'b0; in_valid = 1'b0;
    cycle();
    check("rst_in_ready", 32'(s_in_ready), 1);
    check("rst_occ", 32'(model_cnt()), 0);

    // Back-to-back streaming
    out_ready = 1'b1;
    out_q.delete(); out_t.delete();
    t0 = cyc;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_data  = s2_vals[k];
      cycle();
    end
    in_valid = 1'b0;
    repeat (6) cycle();
    check("stream_cnt", 32'(out_q.size()), 4);
    for (int k = 0; k < 4 && k < out_q.size(); k++) begin
      check("stream_data", 32'(out_q[k]), 32'(s2_vals[k]));
      check("stream_lat", 32'(out_t[k] - t0), 32'(3 + k));
    end

    // Backpressure
    out_ready = 1'b0;
    out_q.delete();
    n_acc = 0;
    in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in_data = 8'(8'hA1 + n_acc);
      cycle();
      if (s_in_ready) n_acc++;
    end
    check("bp_accepts", 32'(n_acc), 3);
    check("bp_in_ready", 32'(s_in_ready), 0);
    check("bp_occ", 32'(model_cnt()), 3);
    check("bp_head_valid", 32'(s_out_valid), 1);
    check("bp_head_data", 32'(s_out_data), 32'h A1);
    in_data = 8'hA4;
    out_ready = 1'b1;
    cycle();
    check("bp_release_rdy", 32'(s_in_ready), 1);
    in_valid = 1'b0;
    repeat (5) cycle();
    check("bp_order_cnt", 32'(out_q.size()), 4);
    for (int k = 0; k < 4 && k < out_q.size(); k++)
      check("bp_order", 32'(out_q[k]), 32'(8'hA1 + k));

    // Full pipeline pass-through
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_data = pt_vals[k];
      cycle();
    end
    out_q.delete();
    out_ready = 1'b1;
    in_data = 8'h55;
    cycle();
    check("pt_in_ready", 32'(s_in_ready), 1);
    check("pt_out_valid", 32'(s_out_valid), 1);
    check("pt_out_data", 32'(s_out_data), 32'h51);
    in_valid = 1'b0;
    out_ready = 1'b0;
    cycle();
    check("pt_occ", 32'(model_cnt()), 3);
    check("pt_next_head", 32'(s_out_data), 32'h52);
    out_ready = 1'b1;
    repeat (5) cycle();
    check("pt_cnt", 32'(out_q.size()), 4);
    for (int k = 0; k < 4 && k < out_q.size(); k++)
      check("pt_order", 32'(out_q[k]), 32'(pt_vals[k]));

    // EN freeze mid-stream
    acc_q.delete(); out_q.delete();
    out_ready = 1'b1;
    for (int k = 0; k < 14; k++) begin
      in_valid = (k < 10);
      in_data  = 8'(8'h60 + k);
      en       = !(k >= 3 && k < 7);
      cycle();
      if (!en) begin
        check("en_out_valid", 32'(s_out_valid), 0);
        check("en_in_ready", 32'(s_in_ready), 0);
      end
    end
    en = 1'b1;
    in_valid = 1'b0;
    repeat (6) cycle();
    check("en_acc_cnt", 32'(acc_q.size()), 6);
    check("en_out_cnt", 32'(out_q.size()), 6);
    for (int k = 0; k < 6 && k < out_q.size(); k++)
      check("en_order", 32'(out_q[k]), 32'(en_vals[k]));

    // Flush with two words in flight
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h71;
    cycle();
    in_data = 8'h72;
    cycle();
    flush = 1'b1;
    cycle();
    check("fl_in_ready", 32'(s_in_ready), 0);
    flush = 1'b0;
    in_valid = 1'b0;
    cycle();
    check("fl_out_valid", 32'(s_out_valid), 0);
    check("fl_occ", 32'(model_cnt()), 0);

    // Reset together with flush clears data
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_data = 8'(8'h81 + k);
      cycle();
    end
    in_valid = 1'b0;
    cycle();
    check("rf_pre_data", 32'(s_out_data), 32'h81);
    rst = 1'b1;
    flush = 1'b1;
    cycle();
    rst = 1'b0;
    flush = 1'b0;
    cycle();
    check("rf_out_valid", 32'(s_out_valid), 0);
    check("rf_out_data", 32'(s_out_data), 0);

    // Randomized traffic against the model
    for (int k = 0; k < 2000; k++) begin
      rst       = ($urandom_range(0, 199) == 0);
      flush     = ($urandom_range(0, 49) == 0);
      en        = ($urandom_range(0, 9) != 0);
      in_valid  = $urandom_range(0, 1) == 1;
      in_data   = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
